// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Types and shared constants for the UART transmit scheduler.
//                It holds the scheduler state encoding and the command byte
//                values that requesters and benches both use.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XMIT = 2'd1,
        GAP  = 2'd2
    } tx_sched_state_t;

    // Command bytes shared between the auth requester and its peers.
    localparam logic [7:0] AUTH_GO   = 8'h67;
    localparam logic [7:0] AUTH_STOP = 8'h73;

endpackage
`default_nettype wire

// File: rtl/uart_tx_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sched_if
//  Description : Bundle between the byte requesters, the scheduler and
//                UART_tx.
//                Requester side : req, req_data (in to scheduler),
//                                 ack, err, gnt (out of scheduler)
//                UART_tx side   : trmt, tx_data (out), tx_done (in)
//                Status         : busy (out)
//                modport master : the scheduler
//                modport slave  : requesters plus UART_tx
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   err;
    logic [NREQ-1:0]   gnt;
    logic              trmt;
    logic [7:0]        tx_data;
    logic              tx_done;
    logic              busy;

    modport master (
        input  req, req_data, tx_done,
        output ack, err, gnt, trmt, tx_data, busy
    );

    modport slave (
        output req, req_data, tx_done,
        input  ack, err, gnt, trmt, tx_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_sched_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb
//  Description : Combinational round-robin pick. Searches req_i starting at
//                ptr_i, wrapping past NREQ-1 back to 0; the first set bit
//                wins.
//  Ports       : req_i   - request vector
//                ptr_i   - index with highest priority this round
//                win_o   - one-hot winner (zero when nothing requests)
//                idx_o   - binary index of the winner
//                valid_o - some request is present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] win_o,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);
    // One spare bit so ptr+offset can exceed NREQ-1 before the wrap.
    localparam int SW = IW + 1;

    logic [SW-1:0] w_sum;
    logic [IW-1:0] w_pos;

    always_comb begin
        win_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, ptr_i} + SW'(k);
            if (w_sum >= SW'(NREQ)) begin
                w_sum = w_sum - SW'(NREQ);
            end
            w_pos = w_sum[IW-1:0];
            if (!valid_o && req_i[w_pos]) begin
                valid_o      = 1'b1;
                win_o[w_pos] = 1'b1;
                idx_o        = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sched
//  Description : Shares one UART_tx between NREQ byte requesters. Grants one
//                requester at a time (round robin), latches its byte, pulses
//                trmt, waits for tx_done (or a timeout), acknowledges, then
//                enforces GAP idle cycles before the next byte.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                bus  - uart_tx_sched_if.master (req/req_data/tx_done in;
//                       ack/err/gnt/trmt/tx_data/busy out, all registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
    parameter int NREQ = 4,
    parameter int GAP  = 16,
    parameter int TMO  = 65535
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_sched_if.master bus
);
    localparam int IW = $clog2(NREQ);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int TW = $clog2(TMO + 1);

    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    localparam logic [1:0] ST_IDLE = uart_pkg::IDLE;
    localparam logic [1:0] ST_XMIT = uart_pkg::XMIT;
    localparam logic [1:0] ST_GAP  = uart_pkg::GAP;

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   ptr_q,   ptr_d;
    logic [IW-1:0]   idx_q,   idx_d;
    logic [NREQ-1:0] gnt_q,   gnt_d;
    logic [NREQ-1:0] ack_q,   ack_d;
    logic [NREQ-1:0] err_q,   err_d;
    logic            trmt_q,  trmt_d;
    logic [7:0]      txd_q,   txd_d;
    logic            busy_q;
    logic [GW-1:0]   gap_q,   gap_d;
    logic [TW-1:0]   tmo_q,   tmo_d;

    logic [NREQ-1:0] w_win;
    logic [IW-1:0]   w_idx;
    logic            w_valid;
    logic [7:0]      w_sel_byte;

    rr_arb #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .win_o   (w_win),
        .idx_o   (w_idx),
        .valid_o (w_valid)
    );

    // Byte of the current winner, selected by its one-hot vector.
    always_comb begin
        w_sel_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win[i]) begin
                w_sel_byte = bus.req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        err_d   = '0;
        trmt_d  = 1'b0;
        txd_d   = txd_q;
        gap_d   = gap_q;
        tmo_d   = tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (w_valid) begin
                    gnt_d   = w_win;
                    idx_d   = w_idx;
                    txd_d   = w_sel_byte;
                    trmt_d  = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_XMIT;
                end
            end
            ST_XMIT: begin
                // tx_done takes priority over a coincident timeout.
                if (bus.tx_done || (tmo_q == TMO_LAST)) begin
                    ack_d   = bus.tx_done ? gnt_q : '0;
                    err_d   = bus.tx_done ? '0 : gnt_q;
                    gnt_d   = '0;
                    ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
                    gap_d   = GAP_LOAD;
                    state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            trmt_q  <= 1'b0;
            txd_q   <= 8'h00;
            busy_q  <= 1'b0;
            gap_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            trmt_q  <= trmt_d;
            txd_q   <= txd_d;
            busy_q  <= (state_d != ST_IDLE);
            gap_q   <= gap_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.ack     = ack_q;
    assign bus.err     = err_q;
    assign bus.gnt     = gnt_q;
    assign bus.trmt    = trmt_q;
    assign bus.tx_data = txd_q;
    assign bus.busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_sched
//  Description : Self-checking bench for uart_tx_sched (NREQ=4, GAP=16,
//                TMO=100). A transaction-level model tracks the round-robin
//                pointer, the loaded byte and the earliest legal trmt cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;
    import uart_pkg::AUTH_GO;
    import uart_pkg::AUTH_STOP;

    localparam int NREQ_P = 4;
    localparam int GAP_P  = 16;
    localparam int TMO_P  = 100;

    logic clk;
    logic rst;

    uart_tx_sched_if #(.NREQ(NREQ_P)) bus ();

    uart_tx_sched #(
        .NREQ (NREQ_P),
        .GAP  (GAP_P),
        .TMO  (TMO_P)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state
    int         ptr_m;
    int         earliest;
    int         req_set_cyc;
    logic [7:0] data_m [NREQ_P];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Round-robin rule: first requesting index at or after p, wrapping.
    function automatic int pick(input logic [NREQ_P-1:0] m, input int p);
        for (int k = 0; k < NREQ_P; k++) begin
            if (m[(p + k) % NREQ_P]) return (p + k) % NREQ_P;
        end
        return -1;
    endfunction

    // Cycle-by-cycle protocol invariants.
    logic [NREQ_P-1:0] prev_gnt = '0;
    always @(negedge clk) begin
        check_eq("ackerr_onehot", {31'd0, $onehot0(bus.ack | bus.err)}, 32'd1);
        check_eq("ack_and_err", {28'd0, bus.ack & bus.err}, 32'd0);
        check_eq("trmt_with_ackerr", {31'd0, bus.trmt & (|(bus.ack | bus.err))}, 32'd0);
        check_eq("ackerr_outside_gnt", {28'd0, (bus.ack | bus.err) & ~prev_gnt}, 32'd0);
        check_eq("gnt_onehot", {31'd0, $onehot0(bus.gnt)}, 32'd1);
        prev_gnt = bus.gnt;
    end

    task automatic set_req(input logic [NREQ_P-1:0] mask, input logic [31:0] dw);
        @(negedge clk);
        bus.req      = mask;
        bus.req_data = dw;
        for (int i = 0; i < NREQ_P; i++) data_m[i] = dw[8*i +: 8];
        req_set_cyc = cyc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_ack", {28'd0, bus.ack}, 32'd0);
        check_eq("rst_err", {28'd0, bus.err}, 32'd0);
        check_eq("rst_gnt", {28'd0, bus.gnt}, 32'd0);
        check_eq("rst_trmt", {31'd0, bus.trmt}, 32'd0);
        check_eq("rst_txdata", {24'd0, bus.tx_data}, 32'd0);
        check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst      = 1'b0;
        ptr_m    = 0;
        earliest = cyc + 1;
    endtask

    // One byte: wait for trmt, check grant and byte, return tx_done d cycles
    // after trmt (never, if d exceeds the timeout), check ack or err.
    task automatic xfer(input int d, input bit refill, input bit drop, input bit chg,
                        input bit keep, output int won);
        bit         got;
        int         w;
        int         cend;
        int         exp_t;
        logic [7:0] dat;
        won = -1;
        got = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (bus.trmt === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("trmt_seen", {31'd0, got}, 32'd1);
        if (!got) return;
        exp_t = (earliest > req_set_cyc + 1) ? earliest : req_set_cyc + 1;
        check_eq("trmt_cycle", cyc, exp_t);
        w = pick(bus.req, ptr_m);
        check_eq("req_present", {31'd0, (w >= 0)}, 32'd1);
        if (w < 0) return;
        won = w;
        dat = data_m[w];
        check_eq("gnt_load", {28'd0, bus.gnt}, 32'd1 << w);
        check_eq("txdata_load", {24'd0, bus.tx_data}, {24'd0, dat});
        check_eq("busy_xmit", {31'd0, bus.busy}, 32'd1);
        if (chg)  bus.req_data[8*w +: 8] = ~dat;
        if (drop) bus.req[w] = 1'b0;
        cend = (d <= TMO_P - 1) ? d + 1 : TMO_P;
        for (int rel = 1; rel <= cend; rel++) begin
            @(negedge clk);
            if (rel < cend) begin
                check_eq("gnt_hold", {28'd0, bus.gnt}, 32'd1 << w);
                check_eq("txdata_hold", {24'd0, bus.tx_data}, {24'd0, dat});
                check_eq("no_early_ackerr", {28'd0, bus.ack | bus.err}, 32'd0);
                check_eq("trmt_single", {31'd0, bus.trmt}, 32'd0);
            end else begin
                if (d <= TMO_P - 1) begin
                    check_eq("ack_pulse", {28'd0, bus.ack}, 32'd1 << w);
                    check_eq("no_err", {28'd0, bus.err}, 32'd0);
                end else begin
                    check_eq("err_pulse", {28'd0, bus.err}, 32'd1 << w);
                    check_eq("no_ack", {28'd0, bus.ack}, 32'd0);
                end
                check_eq("gnt_clear", {28'd0, bus.gnt}, 32'd0);
                check_eq("busy_after", {31'd0, bus.busy}, (GAP_P > 0) ? 32'd1 : 32'd0);
            end
            bus.tx_done = (rel == d) || ((rel == cend) && keep);
        end
        ptr_m    = (w + 1) % NREQ_P;
        earliest = cyc + GAP_P + 2;
        if (!refill) bus.req[w] = 1'b0;
    endtask

    // After a completion with nothing requesting: busy for GAP cycles, then idle.
    task automatic check_gap_idle();
        for (int k = 1; k <= GAP_P + 1; k++) begin
            @(negedge clk);
            check_eq("gap_busy", {31'd0, bus.busy}, (k <= GAP_P) ? 32'd1 : 32'd0);
            check_eq("gap_quiet", {27'd0, bus.trmt, bus.ack | bus.err}, 32'd0);
        end
    endtask

    int         won;
    int         d;
    bit         got;
    logic [3:0] mask;
    logic [31:0] dw;

    initial begin
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        bus.tx_done  = 1'b0;
        ptr_m        = 0;
        earliest     = 0;
        req_set_cyc  = 0;
        for (int i = 0; i < NREQ_P; i++) data_m[i] = 8'h00;
        repeat (3) @(negedge clk);
        do_reset();

        // Single request with gap profile
        set_req(4'b0100, 32'h00A5_0000);
        xfer(10, 1'b0, 1'b0, 1'b0, 1'b0, won);
        check_eq("single_winner", won, 2);
        check_gap_idle();

        // Fairness from ptr=0 with all requesters held
        do_reset();
        set_req(4'b1111, 32'h1312_1110);
        for (int n = 0; n < 5; n++) begin
            xfer(5, 1'b1, 1'b0, 1'b0, 1'b0, won);
            check_eq("fair_order", won, n % 4);
        end
        set_req(4'b0000, 32'h0);

        // Wrap priority: serve 2 so ptr=3, then 0 beats 1
        set_req(4'b0100, 32'h0055_0000);
        xfer(3, 1'b0, 1'b0, 1'b0, 1'b0, won);
        check_eq("wrap_first", won, 2);
        set_req(4'b0011, 32'h0000_2221);
        xfer(4, 1'b0, 1'b0, 1'b0, 1'b0, won);
        check_eq("wrap_req0", won, 0);
        xfer(4, 1'b0, 1'b0, 1'b0, 1'b0, won);
        check_eq("wrap_req1", won, 1);

        // Timeout, then tx_done coincident with the timeout
        set_req(4'b0010, {16'h0, AUTH_GO, 8'h0});
        xfer(150, 1'b0, 1'b0, 1'b0, 1'b0, won);
        check_eq("tmo_winner", won, 1);
        set_req(4'b0010, {16'h0, AUTH_STOP, 8'h0});
        xfer(TMO_P - 1, 1'b0, 1'b0, 1'b0, 1'b0, won);
        check_eq("tie_winner", won, 1);

        // Stale tx_done level through GAP and IDLE
        set_req(4'b0001, 32'h0000_003C);
        xfer(7, 1'b0, 1'b0, 1'b0, 1'b1, won);
        check_gap_idle();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("stale_quiet", {26'd0, bus.busy, bus.trmt, bus.ack | bus.err}, 32'd0);
        end
        bus.tx_done = 1'b0;
        set_req(4'b1000, 32'h9600_0000);
        xfer(6, 1'b0, 1'b0, 1'b0, 1'b0, won);
        check_eq("stale_next", won, 3);

        // Reset mid-XMIT, then service restarts from ptr=0
        set_req(4'b0100, 32'h0077_0000);
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.trmt === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("rstx_trmt", {31'd0, got}, 32'd1);
        repeat (3) @(negedge clk);
        rst          = 1'b1;
        bus.req      = 4'b1010;
        bus.req_data = 32'hB400_B200;
        for (int i = 0; i < NREQ_P; i++) data_m[i] = bus.req_data[8*i +: 8];
        req_set_cyc = cyc;
        @(negedge clk);
        check_eq("rstx_outs", {11'd0, bus.ack, bus.err, bus.gnt, bus.trmt, bus.busy, bus.tx_data}, 32'd0);
        rst      = 1'b0;
        ptr_m    = 0;
        earliest = cyc + 1;
        xfer(4, 1'b0, 1'b0, 1'b0, 1'b0, won);
        check_eq("rstx_from_ptr0", won, 1);
        xfer(4, 1'b0, 1'b0, 1'b0, 1'b0, won);
        check_eq("rstx_second", won, 3);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            if (bus.req == '0) begin
                mask = 4'($urandom_range(1, 15));
                for (int i = 0; i < NREQ_P; i++) begin
                    case ($urandom_range(0, 3))
                        0:       dw[8*i +: 8] = AUTH_GO;
                        1:       dw[8*i +: 8] = AUTH_STOP;
                        default: dw[8*i +: 8] = 8'($urandom);
                    endcase
                end
                set_req(mask, dw);
            end
            case ($urandom_range(0, 7))
                0:       d = TMO_P - 1;
                1:       d = 150;
                default: d = $urandom_range(1, 12);
            endcase
            xfer(d, 1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'b0, won);
        end

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
